// File: rtl/wptr_full.sv
// Write-side pointer and full/level controller for the async FIFO.
// Read pointer arrives Gray-coded and already synchronised into i_wclk.
module wptr_full #(
  parameter int ADDR_WIDTH   = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic                  i_wclk,
  input  logic                  i_wrst_n,
  input  logic                  i_winc,
  input  logic                  i_clr_ovf,
  input  logic [ADDR_WIDTH:0]   i_wq2_rptr,
  output logic                  o_wen,
  output logic [ADDR_WIDTH-1:0] o_waddr,
  output logic [ADDR_WIDTH:0]   o_wptr,
  output logic                  o_wfull,
  output logic                  o_wafull,
  output logic [ADDR_WIDTH:0]   o_wlevel,
  output logic                  o_overflow
);

  localparam int AW = ADDR_WIDTH;
  localparam logic [AW:0] THR = (AW+1)'(AFULL_THRESH);

  logic [AW:0] r_wbin;
  logic [AW:0] r_wptr;
  logic        r_wfull;
  logic        r_wafull;
  logic [AW:0] r_wlevel;
  logic        r_ovf;

  logic [AW:0] w_wbin_next;
  logic [AW:0] w_wgray_next;
  logic [AW:0] w_rbin;
  logic [AW:0] w_level_next;
  logic [AW:0] w_full_cmp;
  logic        w_full_next;

  assign o_wen = i_winc & ~r_wfull & i_wrst_n;

  assign w_wbin_next  = r_wbin + {{AW{1'b0}}, o_wen};
  assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;

  always_comb begin
    w_rbin = '0;
    w_rbin[AW] = i_wq2_rptr[AW];
    for (int i = AW - 1; i >= 0; i--) begin
      w_rbin[i] = w_rbin[i+1] ^ i_wq2_rptr[i];
    end
  end

  // Full when the write pointer is one lap ahead of the synced read pointer
  assign w_full_cmp = {~i_wq2_rptr[AW:AW-1], i_wq2_rptr[AW-2:0]};
  assign w_full_next = (w_wgray_next == w_full_cmp);
  assign w_level_next = w_wbin_next - w_rbin;

  always_ff @(posedge i_wclk) begin
    if (!i_wrst_n) begin
      r_wbin   <= '0;
      r_wptr   <= '0;
      r_wfull  <= 1'b0;
      r_wafull <= 1'b0;
      r_wlevel <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_wbin   <= w_wbin_next;
      r_wptr   <= w_wgray_next;
      r_wfull  <= w_full_next;
      r_wafull <= (w_level_next >= THR);
      r_wlevel <= w_level_next;
      if (i_winc && r_wfull) begin
        r_ovf <= 1'b1;
      end else if (i_clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign o_waddr    = r_wbin[AW-1:0];
  assign o_wptr     = r_wptr;
  assign o_wfull    = r_wfull;
  assign o_wafull   = r_wafull;
  assign o_wlevel   = r_wlevel;
  assign o_overflow = r_ovf;

endmodule

// File: tb/tb_wptr_full.sv
// Directed bench for wptr_full: reset, fill, overflow, drain
// and a wrap stream against a lagging reader with a write scoreboard.
module tb_wptr_full;

  logic       clk = 1'b0;
  logic       wrst_n;
  logic       winc;
  logic       clr_ovf;
  logic [3:0] rptr;
  logic       wen;
  logic [2:0] waddr;
  logic [3:0] wptr;
  logic       wfull;
  logic       wafull;
  logic [3:0] wlevel;
  logic       ovf;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wptr_full #(.ADDR_WIDTH(3), .AFULL_THRESH(6)) dut (
    .i_wclk     (clk),
    .i_wrst_n   (wrst_n),
    .i_winc     (winc),
    .i_clr_ovf  (clr_ovf),
    .i_wq2_rptr (rptr),
    .o_wen      (wen),
    .o_waddr    (waddr),
    .o_wptr     (wptr),
    .o_wfull    (wfull),
    .o_wafull   (wafull),
    .o_wlevel   (wlevel),
    .o_overflow (ovf)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    b[2] = b[3] ^ g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

  function automatic logic [3:0] b2g(input logic [3:0] b);
    return (b >> 1) ^ b;
  endfunction

  logic [3:0] gtab [0:7];
  logic       valid [0:7];
  logic [3:0] m_wbin, rb, q1, q2, fed, lvl, prev;
  logic       m_full, m_wen, pop;
  int         acc, cyc;

  initial begin
    gtab[0] = 4'h0; gtab[1] = 4'h1; gtab[2] = 4'h3; gtab[3] = 4'h2;
    gtab[4] = 4'h6; gtab[5] = 4'h7; gtab[6] = 4'h5; gtab[7] = 4'h4;

    wrst_n = 1'b0; winc = 1'b1; clr_ovf = 1'b0; rptr = 4'h0;
    #1;
    tick();
    tick();
    check("rst_wen", 32'(wen), 32'd0);
    check("rst_wptr", 32'(wptr), 32'd0);
    check("rst_waddr", 32'(waddr), 32'd0);
    check("rst_wfull", 32'(wfull), 32'd0);
    check("rst_wafull", 32'(wafull), 32'd0);
    check("rst_wlevel", 32'(wlevel), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);

    wrst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("fill_wen", 32'(wen), 32'd1);
      check("fill_waddr", 32'(waddr), 32'(i));
      check("fill_wptr", 32'(wptr), 32'(gtab[i]));
      tick();
      check("fill_level", 32'(wlevel), 32'(i + 1));
      check("fill_afull", 32'(wafull), 32'(i + 1 >= 6));
      check("fill_full", 32'(wfull), 32'(i + 1 == 8));
    end
    check("fill_wptr_end", 32'(wptr), 32'hC);

    #1;
    check("ovf_wen", 32'(wen), 32'd0);
    tick();
    check("ovf_wptr", 32'(wptr), 32'hC);
    check("ovf_waddr", 32'(waddr), 32'd0);
    check("ovf_set", 32'(ovf), 32'd1);
    winc = 1'b0; clr_ovf = 1'b1;
    tick();
    check("ovf_clr", 32'(ovf), 32'd0);

    winc = 1'b1; clr_ovf = 1'b1;
    tick();
    check("ovf_setwins", 32'(ovf), 32'd1);
    winc = 1'b0;
    tick();
    clr_ovf = 1'b0;
    check("ovf_clr2", 32'(ovf), 32'd0);

    rptr = 4'b0110;
    tick();
    check("drain_full", 32'(wfull), 32'd0);
    check("drain_level", 32'(wlevel), 32'd4);
    check("drain_afull", 32'(wafull), 32'd0);
    winc = 1'b1;
    tick();
    winc = 1'b0;
    check("drain_push_lvl", 32'(wlevel), 32'd5);
    check("drain_waddr", 32'(waddr), 32'd1);
    check("drain_wptr", 32'(wptr), 32'hD);

    wrst_n = 1'b0; winc = 1'b1;
    #1;
    check("midrst_wen", 32'(wen), 32'd0);
    tick();
    check("midrst_wptr", 32'(wptr), 32'd0);
    check("midrst_level", 32'(wlevel), 32'd0);
    check("midrst_waddr", 32'(waddr), 32'd0);

    wrst_n = 1'b1; rptr = 4'h0;
    m_wbin = 4'h0; m_full = 1'b0; rb = 4'h0; q1 = 4'h0; q2 = 4'h0;
    for (int i = 0; i < 8; i++) valid[i] = 1'b0;
    acc = 0; cyc = 0;
    while (acc < 40 && cyc < 400) begin
      winc = 1'b1;
      rptr = q2;
      fed = q2;
      #1;
      pop = (cyc % 2 == 1) && valid[rb[2:0]];
      m_wen = winc & ~m_full;
      check("wrap_wen", 32'(wen), 32'(m_wen));
      if (m_wen) begin
        check("wrap_waddr", 32'(waddr), 32'(m_wbin[2:0]));
        check("wrap_no_overwrite", 32'(valid[m_wbin[2:0]]), 32'd0);
        valid[m_wbin[2:0]] = 1'b1;
        acc++;
      end
      if (pop) begin
        valid[rb[2:0]] = 1'b0;
        rb = rb + 4'd1;
      end
      prev = wptr;
      tick();
      m_wbin = m_wbin + 4'(m_wen);
      lvl = m_wbin - g2b(fed);
      m_full = (lvl == 4'd8);
      check("wrap_wptr", 32'(wptr), 32'(b2g(m_wbin)));
      check("wrap_gray_step", 32'($countones(wptr ^ prev)), 32'(m_wen));
      check("wrap_msb", 32'(wptr[3]), 32'(m_wbin[3]));
      check("wrap_level", 32'(wlevel), 32'(lvl));
      check("wrap_full", 32'(wfull), 32'(m_full));
      check("wrap_afull", 32'(wafull), 32'(lvl >= 4'd6));
      q2 = q1;
      q1 = b2g(rb);
      cyc++;
    end
    winc = 1'b0;
    check("wrap_done", 32'(acc), 32'd40);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wptr_full.md
Name: wptr_full

Overview:
- Write-domain pointer and full-flag controller for the async FIFO. It is the write-side counterpart of the read pointer/empty logic.
- Maintains a binary write counter and its Gray-coded pointer. Detects full against the read pointer, which arrives already synchronised into the write domain.
- Produces the memory write address and write enable, a fill-level estimate, almost-full, and a sticky overflow error.
- Sits between the writer client, the dual-port FIFO memory and the rptr-to-wclk synchroniser.

Parameters:
- ADDR_WIDTH, 3: FIFO depth is 2**ADDR_WIDTH. Minimum legal value is 2.
- AFULL_THRESH, 6: level at or above which o_wafull asserts. Legal range is 1..2**ADDR_WIDTH.

Ports:
- i_wclk  in  1  write-domain clock
- i_wrst_n  in  1  synchronous active-low reset, sampled on posedge i_wclk
- i_winc  in  1  writer requests a push this cycle
- i_clr_ovf  in  1  clears the sticky overflow flag
- i_wq2_rptr  in  ADDR_WIDTH+1  Gray read pointer, two-flop synchronised into i_wclk
- o_wen  out  1  memory write enable
- o_waddr  out  ADDR_WIDTH  memory write address (binary)
- o_wptr  out  ADDR_WIDTH+1  registered Gray write pointer, sent to the read-domain synchroniser
- o_wfull  out  1  FIFO full, registered
- o_wafull  out  1  almost full, registered
- o_wlevel  out  ADDR_WIDTH+1  estimated entries stored, registered
- o_overflow  out  1  sticky: a push was attempted while full

Behaviour:
- Single clock i_wclk. Reset is synchronous, active-low. All state updates on posedge i_wclk only.
- Reset values (i_wrst_n low at a clock edge, regardless of other inputs):
  - internal binary counter wbin = 0
  - o_wptr = 0, o_waddr = 0, o_wfull = 0, o_wafull = 0, o_wlevel = 0, o_overflow = 0
- o_wen = i_winc & ~o_wfull & i_wrst_n, combinational, so the memory never writes during reset or when full.
- Next-state computation:
  - wbin_next = wbin + o_wen, modulo 2**(ADDR_WIDTH+1).
  - wgray_next = (wbin_next >> 1) ^ wbin_next.
  - Register: wbin <= wbin_next, o_wptr <= wgray_next.
  - o_waddr = wbin[ADDR_WIDTH-1:0]. It is the address of the current cycle's write, and advances one cycle after each accepted push.
- Full detection:
  - full_next = (wgray_next == {~i_wq2_rptr[AW:AW-1], i_wq2_rptr[AW-2:0]}), where AW = ADDR_WIDTH.
  - o_wfull <= full_next, so it is valid in the cycle after the push that fills the FIFO.
  - Full is pessimistic. After the reader pops, o_wfull stays high until the synchronised pointer changes, about 2 write clocks later.
  - Full is never deasserted early, and never asserted while space exists by the synchronised view.
- Level:
  - rbin = Gray-to-binary of i_wq2_rptr, combinational (rbin[AW] = g[AW]; rbin[i] = rbin[i+1] ^ g[i]).
  - level_next = (wbin_next - rbin) modulo 2**(AW+1); range 0..2**AW.
  - o_wlevel <= level_next.
  - o_wafull <= (level_next >= AFULL_THRESH).
  - o_wlevel == 2**AW exactly when o_wfull is high; the two must stay consistent.
- Overflow:
  - Set when i_winc & o_wfull is true at an edge.
  - Cleared when i_clr_ovf is high.
  - If set and clear occur in the same cycle, set wins.
  - Pointer and address do not move on a rejected push.
- Wrap-around:
  - wbin wraps from 2**(AW+1)-1 to 0 with no special handling.
  - The Gray pointer changes exactly one bit per accepted push, including at wrap.
- Simultaneous events: a push together with a read-pointer advance resolves through wbin_next and rbin in the same cycle. Level is unchanged net if both advance by one.
- Reset mid-operation: the next edge with i_wrst_n low returns all state to reset values. Any i_winc during that cycle is dropped.

Test Plan:
- Reset: ADDR_WIDTH=3. Hold i_wrst_n=0 for 2 clocks with i_winc=1 -> o_wen=0, all outputs 0, no pointer movement.
- Fill: i_wq2_rptr=0, 8 back-to-back pushes ->
  - o_waddr steps 0..7
  - o_wptr steps 0,1,3,2,6,7,5,4,0xC
  - o_wafull high after the 6th push (level 6)
  - o_wfull high, level 8, after the 8th push
- Overflow: while full, i_winc=1 -> o_wen=0, o_wptr holds 0xC, o_overflow=1 next cycle. Pulse i_clr_ovf -> o_overflow=0.
- Set-wins: while full, i_winc=1 and i_clr_ovf=1 in the same cycle -> o_overflow=1.
- Drain: from full, set i_wq2_rptr=4'b0110 (rbin 4) -> next cycle o_wfull=0, o_wlevel=4, o_wafull=0. One push -> level 5.
- Wrap: stream 40 pushes while a reader model feeds the synchronised pointer with a 2-cycle lag ->
  - o_wptr stays Gray (one bit change per push)
  - the counter MSB toggles at each 8-push boundary
  - full never asserts while level < 8
  - a scoreboard of memory writes shows no overwrite of unread data
